// File: rtl/pmp_seq_checker.sv
// pmp_seq_checker
// Area-reduced PMP checker. One shared TOR/NA4/NAPOT decode datapath is
// time-multiplexed across the PMP entries, one entry per cycle, lowest
// index first. The first entry that matches ends the scan.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   ReqValid/ReqReady  request handshake (ReqReady only in IDLE)
//   ReqPA              physical address to check
//   ReqRead/Write/Execute/MMode   access type and effective privilege
//   Flush              abort any operation, no response is produced
//   PMPCfgFlat         pmpcfg bytes, entry i at [8i+7:8i]
//   PMPAdrFlat         pmpaddr values, entry i is (PA_BITS-2) bits wide
//   RespValid/RespReady   response handshake
//   RespFault          access fault
//   RespMatched        some entry matched
//   RespIdx            index of the matching entry (0 if none)
//
// state | meaning
// IDLE  | waiting for a request, ReqReady=1
// SCAN  | decoding entry idx_q against the latched address
// DONE  | response held until RespReady
module pmp_seq_checker #(
    parameter int PA_BITS     = 56,
    parameter int PMP_ENTRIES = 16,
    parameter int IDX_BITS    = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ReqValid,
    output logic                               ReqReady,
    input  logic [PA_BITS-1:0]                 ReqPA,
    input  logic                               ReqRead,
    input  logic                               ReqWrite,
    input  logic                               ReqExecute,
    input  logic                               ReqMMode,
    input  logic                               Flush,
    input  logic [8*PMP_ENTRIES-1:0]           PMPCfgFlat,
    input  logic [(PA_BITS-2)*PMP_ENTRIES-1:0] PMPAdrFlat,
    output logic                               RespValid,
    input  logic                               RespReady,
    output logic                               RespFault,
    output logic                               RespMatched,
    output logic [IDX_BITS-1:0]                RespIdx
);

    localparam int AW = PA_BITS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PA_BITS-1:0]  pa_q;
    logic                rd_q, wr_q, ex_q, mmode_q;
    logic [IDX_BITS-1:0] idx_q;
    logic                pa_ge_prev_q;
    logic                fault_q, matched_q;
    logic [IDX_BITS-1:0] resp_idx_q;

    logic [7:0]    cfg_arr [PMP_ENTRIES];
    logic [AW-1:0] adr_arr [PMP_ENTRIES];

    for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_unpack
        assign cfg_arr[i] = PMPCfgFlat[8*i +: 8];
        assign adr_arr[i] = PMPAdrFlat[AW*i +: AW];
    end

    // Shared decode datapath for the entry selected by idx_q
    logic [7:0]     cur_cfg;
    logic [AW-1:0]  cur_adr;
    logic [PA_BITS:0] pa_ext, bound_ext;
    logic           pa_ge_cur, pa_lt_cur;
    logic [AW-1:0]  napot_mask;
    logic           hit, last_entry, hit_fault;

    assign cur_cfg   = cfg_arr[idx_q];
    assign cur_adr   = adr_arr[idx_q];
    assign pa_ext    = {1'b0, pa_q};
    assign bound_ext = {1'b0, cur_adr, 2'b00};
    assign pa_ge_cur = (pa_ext >= bound_ext);
    assign pa_lt_cur = (pa_ext <  bound_ext);

    // adr ^ (adr+1) sets the k trailing ones plus the following zero:
    // exactly the word-address bits that are "don't care" in a NAPOT region.
    assign napot_mask = cur_adr ^ (cur_adr + AW'(1));

    always_comb begin
        hit = 1'b0;
        case (cur_cfg[4:3])
            2'b01:   hit = pa_ge_prev_q & pa_lt_cur;
            2'b10:   hit = (pa_q[PA_BITS-1:2] == cur_adr);
            2'b11:   hit = (((pa_q[PA_BITS-1:2] ^ cur_adr) & ~napot_mask) == '0);
            default: hit = 1'b0;
        endcase
    end

    assign last_entry = (idx_q == IDX_BITS'(PMP_ENTRIES - 1));

    // M-mode bypasses unlocked entries; otherwise the RWX bits apply
    assign hit_fault = (mmode_q & ~cur_cfg[7]) ? 1'b0 :
                       ((rd_q & ~cur_cfg[0]) | (wr_q & ~cur_cfg[1]) | (ex_q & ~cur_cfg[2]));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ReqValid)           state_d = SCAN;
            SCAN:    if (hit || last_entry)  state_d = DONE;
            DONE:    if (RespReady)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
        if (Flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pa_q         <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ex_q         <= 1'b0;
            mmode_q      <= 1'b0;
            idx_q        <= '0;
            pa_ge_prev_q <= 1'b1;
            fault_q      <= 1'b0;
            matched_q    <= 1'b0;
            resp_idx_q   <= '0;
        end else if (Flush) begin
            idx_q        <= '0;
            fault_q      <= 1'b0;
            matched_q    <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        pa_q         <= ReqPA;
                        rd_q         <= ReqRead;
                        wr_q         <= ReqWrite;
                        ex_q         <= ReqExecute;
                        mmode_q      <= ReqMMode;
                        idx_q        <= '0;
                        // entry 0's TOR region starts at address 0
                        pa_ge_prev_q <= 1'b1;
                    end
                end
                SCAN: begin
                    pa_ge_prev_q <= pa_ge_cur;
                    idx_q        <= idx_q + IDX_BITS'(1);
                    if (hit) begin
                        matched_q  <= 1'b1;
                        resp_idx_q <= idx_q;
                        fault_q    <= hit_fault;
                    end else if (last_entry) begin
                        matched_q  <= 1'b0;
                        resp_idx_q <= '0;
                        fault_q    <= ~mmode_q;
                    end
                end
                DONE: begin
                    if (RespReady) begin
                        matched_q  <= 1'b0;
                        resp_idx_q <= '0;
                        fault_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ReqReady    = (state_q == IDLE);
    assign RespValid   = (state_q == DONE);
    assign RespFault   = fault_q;
    assign RespMatched = matched_q;
    assign RespIdx     = resp_idx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed testbench for pmp_seq_checker (PA_BITS=56, 16 entries).
module tb_pmp_seq_checker;

    localparam int PA = 56;
    localparam int N  = 16;
    localparam int AW = PA - 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ReqValid = 1'b0;
    logic          ReqReady;
    logic [PA-1:0] ReqPA = '0;
    logic          ReqRead = 1'b0, ReqWrite = 1'b0, ReqExecute = 1'b0, ReqMMode = 1'b0;
    logic          Flush = 1'b0;
    logic [8*N-1:0]  PMPCfgFlat;
    logic [AW*N-1:0] PMPAdrFlat;
    logic          RespValid;
    logic          RespReady = 1'b0;
    logic          RespFault, RespMatched;
    logic [3:0]    RespIdx;

    logic [7:0]    cfg_t [N];
    logic [AW-1:0] adr_t [N];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    always_comb begin
        PMPCfgFlat = '0;
        PMPAdrFlat = '0;
        for (int i = 0; i < N; i++) begin
            PMPCfgFlat[8*i +: 8]   = cfg_t[i];
            PMPAdrFlat[AW*i +: AW] = adr_t[i];
        end
    end

    pmp_seq_checker #(.PA_BITS(PA), .PMP_ENTRIES(N)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqPA(ReqPA),
        .ReqRead(ReqRead), .ReqWrite(ReqWrite), .ReqExecute(ReqExecute), .ReqMMode(ReqMMode),
        .Flush(Flush), .PMPCfgFlat(PMPCfgFlat), .PMPAdrFlat(PMPAdrFlat),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespFault(RespFault), .RespMatched(RespMatched), .RespIdx(RespIdx)
    );

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_t[i] = 8'h00;
            adr_t[i] = '0;
        end
    endtask

    // Issue one request from IDLE; lat = cycle (accept = cycle 0) at which
    // RespValid is first seen, 99 if it never appears. Returns at that negedge.
    task automatic do_req(input logic [PA-1:0] pa, input logic r, input logic w,
                          input logic x, input logic m, output int lat);
        ReqPA = pa; ReqRead = r; ReqWrite = w; ReqExecute = x; ReqMMode = m;
        ReqValid = 1'b1;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (RespValid === 1'b1) break;
            if (lat >= 40) begin lat = 99; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        RespReady = 1'b1;
        @(posedge clk); #1;
        RespReady = 1'b0;
    endtask

    // Compares latency/matched/idx/fault of the response currently presented
    task automatic check_resp(input string name, input int lat, input int elat,
                              input logic em, input logic [3:0] ei, input logic ef);
        checks++;
        if (lat !== elat) begin fails++; $display("FAIL %s_lat got %0d exp %0d", name, lat, elat); end
        checks++;
        if (RespMatched !== em) begin fails++; $display("FAIL %s_matched got %b exp %b", name, RespMatched, em); end
        checks++;
        if (RespIdx !== ei) begin fails++; $display("FAIL %s_idx got %0d exp %0d", name, RespIdx, ei); end
        checks++;
        if (RespFault !== ef) begin fails++; $display("FAIL %s_fault got %b exp %b", name, RespFault, ef); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ReqReady !== 1'b1) begin fails++; $display("FAIL reset_reqready got %b exp 1", ReqReady); end
        checks++;
        if (RespValid !== 1'b0) begin fails++; $display("FAIL reset_respvalid got %b exp 0", RespValid); end
        checks++;
        if ({RespFault, RespMatched, RespIdx} !== 6'b0) begin
            fails++; $display("FAIL reset_outputs got %b exp 000000", {RespFault, RespMatched, RespIdx});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_napot();
        int lat;
        clear_cfg();
        cfg_t[0] = 8'h1F; adr_t[0] = 54'h200001FF;
        do_req(56'h80000FFC, 1, 0, 0, 0, lat);
        check_resp("napot_top_word", lat, 2, 1'b1, 4'd0, 1'b0);
        take_resp();
        do_req(56'h80001000, 1, 0, 0, 0, lat);
        check_resp("napot_past_end", lat, 17, 1'b0, 4'd0, 1'b1);
        take_resp();
    endtask

    task automatic test_tor();
        int lat;
        clear_cfg();
        cfg_t[0] = 8'h00; adr_t[0] = 54'h20000000;
        cfg_t[1] = 8'h09; adr_t[1] = 54'h20000400;
        do_req(56'h80000800, 0, 1, 0, 0, lat);
        check_resp("tor_u_write", lat, 3, 1'b1, 4'd1, 1'b1);
        take_resp();
        do_req(56'h80000800, 1, 0, 0, 0, lat);
        check_resp("tor_u_read", lat, 3, 1'b1, 4'd1, 1'b0);
        take_resp();
        do_req(56'h80001000, 1, 0, 0, 0, lat);
        check_resp("tor_at_hi", lat, 17, 1'b0, 4'd0, 1'b1);
        take_resp();
        do_req(56'h7FFFFFFC, 1, 0, 0, 0, lat);
        check_resp("tor_below_lo", lat, 17, 1'b0, 4'd0, 1'b1);
        take_resp();
        do_req(56'h80000000, 1, 0, 0, 0, lat);
        check_resp("tor_at_lo", lat, 3, 1'b1, 4'd1, 1'b0);
        take_resp();
    endtask

    task automatic test_all_off();
        int lat;
        clear_cfg();
        do_req(56'h0, 1, 0, 0, 1, lat);
        check_resp("off_m_read", lat, 17, 1'b0, 4'd0, 1'b0);
        take_resp();
        do_req(56'h0, 1, 0, 0, 0, lat);
        check_resp("off_u_read", lat, 17, 1'b0, 4'd0, 1'b1);
        take_resp();
    endtask

    task automatic test_lock_and_priority();
        int lat;
        clear_cfg();
        cfg_t[2] = 8'h98; adr_t[2] = 54'h20000000;
        do_req(56'h80000002, 0, 0, 1, 1, lat);
        check_resp("locked_m_fetch", lat, 4, 1'b1, 4'd2, 1'b1);
        take_resp();
        cfg_t[2] = 8'h18;
        do_req(56'h80000002, 0, 0, 1, 1, lat);
        check_resp("unlocked_m_fetch", lat, 4, 1'b1, 4'd2, 1'b0);
        take_resp();
        clear_cfg();
        cfg_t[0] = 8'h1C; adr_t[0] = 54'h20000000;
        cfg_t[5] = 8'h18; adr_t[5] = 54'h20000000;
        do_req(56'h80000002, 0, 0, 1, 0, lat);
        check_resp("overlap_first_wins", lat, 2, 1'b1, 4'd0, 1'b0);
        take_resp();
        clear_cfg();
        cfg_t[3] = 8'h17; adr_t[3] = 54'h20000001;
        do_req(56'h80000004, 1, 0, 0, 0, lat);
        check_resp("na4_hit", lat, 5, 1'b1, 4'd3, 1'b0);
        take_resp();
        do_req(56'h80000008, 1, 0, 0, 0, lat);
        check_resp("na4_next_word", lat, 17, 1'b0, 4'd0, 1'b1);
        take_resp();
    endtask

    task automatic test_flush_reset();
        int lat;
        logic seen;
        clear_cfg();
        ReqPA = 56'h0; ReqRead = 1'b1; ReqWrite = 1'b0; ReqExecute = 1'b0; ReqMMode = 1'b0;
        ReqValid = 1'b1;
        @(posedge clk); #1 ReqValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        Flush = 1'b1;
        @(posedge clk); #1 Flush = 1'b0;
        checks++;
        if (ReqReady !== 1'b1) begin fails++; $display("FAIL flush_reqready got %b exp 1", ReqReady); end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (RespValid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_resp got %b exp 0", seen); end

        ReqValid = 1'b1;
        @(posedge clk); #1 ReqValid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checks++;
        if ({ReqReady, RespValid} !== 2'b10) begin
            fails++; $display("FAIL reset_midscan got %b exp 10", {ReqReady, RespValid});
        end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (RespValid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL reset_midscan_no_resp got %b exp 0", seen); end

        cfg_t[1] = 8'h09; adr_t[1] = 54'h20000400;
        do_req(56'h80000800, 0, 1, 0, 0, lat);
        check_resp("pre_reset_done", lat, 3, 1'b1, 4'd1, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checks++;
        if ({ReqReady, RespValid, RespFault, RespMatched, RespIdx} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_in_done got %b exp 10000000",
                     {ReqReady, RespValid, RespFault, RespMatched, RespIdx});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        clear_cfg();
        cfg_t[1] = 8'h09; adr_t[1] = 54'h20000400;
        do_req(56'h80000800, 0, 1, 0, 0, lat);
        check_resp("b2b_first", lat, 3, 1'b1, 4'd1, 1'b1);
        // a pending request must not be taken while the response is held
        ReqPA = 56'h80000000; ReqRead = 1'b1; ReqWrite = 1'b0; ReqExecute = 1'b0; ReqMMode = 1'b0;
        ReqValid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({RespValid, RespFault, RespIdx, ReqReady} !== 7'b1_1_0001_0) begin
                fails++;
                $display("FAIL b2b_hold cycle %0d got %b exp 1100010", c,
                         {RespValid, RespFault, RespIdx, ReqReady});
            end
        end
        RespReady = 1'b1;
        @(posedge clk); #1 RespReady = 1'b0;
        checks++;
        if ({RespValid, ReqReady} !== 2'b01) begin
            fails++; $display("FAIL b2b_release got %b exp 01", {RespValid, ReqReady});
        end
        do_req(56'h80000000, 1, 0, 0, 0, lat);
        check_resp("b2b_second", lat, 3, 1'b1, 4'd1, 1'b0);
        take_resp();
    endtask

    initial begin
        clear_cfg();
        test_reset();
        test_napot();
        test_tor();
        test_all_off();
        test_lock_and_priority();
        test_flush_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
